// File: rtl/packet_rx.sv
// packet_rx: Ethernet receive front end.
// Finds preamble/SFD on a byte-wide stream, accepts frames whose destination
// MAC equals mac_addr, and writes the first BUF_LEN payload bytes into an
// external dual-port RAM. eth_rx_ready tells the CPU a full payload is
// buffered; the CPU hands the buffer back with a one-cycle eth_rx_read pulse.
//
// Handshake: eth_rx_ready is a level owned by this block. It rises one cycle
// after the frame ends (ctl back to idle) and falls the cycle after the CPU
// pulses eth_rx_read. While it is high, new frames are dropped so the buffer
// is never overwritten. A set and a read in the same cycle leave it set.
//
// Timing: data/ctl are registered on entry and every output is registered,
// so a byte presented in cycle n produces its RAM write strobe in cycle n+2.
module packet_rx #(
    parameter int HDR_LEN = 14,
    parameter int BUF_LEN = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  data,
    input  logic [1:0]  ctl,
    input  logic [47:0] mac_addr,
    output logic [5:0]  eth_rx_addr,
    output logic [7:0]  eth_rx_wdata,
    output logic        eth_rx_we,
    output logic        eth_rx_ready,
    input  logic        eth_rx_read,
    output logic [2:0]  fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_DMAC     = 3'd2,
        S_SKIP     = 3'd3,
        S_CAPTURE  = 3'd4,
        S_DRAIN    = 3'd5,
        S_DROP     = 3'd6
    } state_t;

    // Header byte index counter: 0..5 dest MAC, 6..HDR_LEN-1 skipped,
    // HDR_LEN..HDR_LEN+BUF_LEN-1 payload.
    localparam logic [6:0] MAC_LAST  = 7'd5;
    localparam logic [6:0] HDR_BASE  = 7'(HDR_LEN);
    localparam logic [6:0] HDR_LAST  = 7'(HDR_LEN - 1);
    localparam logic [6:0] BYTE_LAST = 7'(HDR_LEN + BUF_LEN - 1);

    state_t      state, state_next;
    logic [7:0]  data_q;
    logic [1:0]  ctl_q;
    logic [6:0]  cnt, cnt_next;
    logic [5:0]  addr_next;
    logic [7:0]  wdata_next;
    logic        we_next;
    logic        ready_next;
    logic [7:0]  mac_byte;
    logic        byte_valid, byte_idle, byte_err;

    assign byte_valid = (ctl_q == 2'b11);
    assign byte_idle  = (ctl_q == 2'b00);
    assign byte_err   = ^ctl_q;
    assign fsm_state  = state;

    // Register the incoming byte stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= 8'h00;
            ctl_q  <= 2'b00;
        end else begin
            data_q <= data;
            ctl_q  <= ctl;
        end
    end

    // Select the expected destination MAC byte; first wire byte is [47:40].
    always_comb begin
        mac_byte = mac_addr[7:0];
        case (cnt[2:0])
            3'd0:    mac_byte = mac_addr[47:40];
            3'd1:    mac_byte = mac_addr[39:32];
            3'd2:    mac_byte = mac_addr[31:24];
            3'd3:    mac_byte = mac_addr[23:16];
            3'd4:    mac_byte = mac_addr[15:8];
            default: mac_byte = mac_addr[7:0];
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (byte_valid) begin
                    if (eth_rx_ready || data_q != 8'h55) state_next = S_DROP;
                    else                                 state_next = S_PREAMBLE;
                end
            end
            S_PREAMBLE: begin
                if (byte_err)       state_next = S_DROP;
                else if (byte_idle) state_next = S_IDLE;
                else if (data_q == 8'hD5) state_next = S_DMAC;
                else if (data_q != 8'h55) state_next = S_DROP;
            end
            S_DMAC: begin
                if (byte_err)                state_next = S_DROP;
                else if (byte_idle)          state_next = S_IDLE;
                else if (data_q != mac_byte) state_next = S_DROP;
                else if (cnt == MAC_LAST)    state_next = S_SKIP;
            end
            S_SKIP: begin
                if (byte_err)             state_next = S_DROP;
                else if (byte_idle)       state_next = S_IDLE;
                else if (cnt == HDR_LAST) state_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (byte_err)              state_next = S_DROP;
                else if (byte_idle)        state_next = S_IDLE;
                else if (cnt == BYTE_LAST) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (byte_err)       state_next = S_DROP;
                else if (byte_idle) state_next = S_IDLE;
            end
            S_DROP: begin
                if (byte_idle) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output / datapath next values: counter, RAM write, ready flag.
    always_comb begin
        cnt_next   = cnt;
        we_next    = 1'b0;
        addr_next  = eth_rx_addr;
        wdata_next = eth_rx_wdata;
        case (state)
            S_PREAMBLE: begin
                if (byte_valid && data_q == 8'hD5) cnt_next = 7'd0;
            end
            S_DMAC, S_SKIP: begin
                if (byte_valid) cnt_next = cnt + 7'd1;
            end
            S_CAPTURE: begin
                if (byte_valid) begin
                    cnt_next   = cnt + 7'd1;
                    we_next    = 1'b1;
                    addr_next  = 6'(cnt - HDR_BASE);
                    wdata_next = data_q;
                end
            end
            default: ;
        endcase
        // Frame completion takes priority over a coincident CPU release.
        if (state == S_DRAIN && byte_idle) ready_next = 1'b1;
        else if (eth_rx_read)              ready_next = 1'b0;
        else                               ready_next = eth_rx_ready;
    end

    // Registered outputs and byte counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= 7'd0;
            eth_rx_we    <= 1'b0;
            eth_rx_addr  <= 6'd0;
            eth_rx_wdata <= 8'h00;
            eth_rx_ready <= 1'b0;
        end else begin
            cnt          <= cnt_next;
            eth_rx_we    <= we_next;
            eth_rx_addr  <= addr_next;
            eth_rx_wdata <= wdata_next;
            eth_rx_ready <= ready_next;
        end
    end

endmodule

// File: tb/tb_packet_rx.sv
// Bench for packet_rx: directed frames, RAM writes checked against an
// expected queue by an independent monitor.
module tb_packet_rx;

    localparam logic [47:0] MAC = 48'h31_41_59_26_53_58;

    logic        clk;
    logic        rst_n;
    logic [7:0]  data;
    logic [1:0]  ctl;
    logic [47:0] mac_addr;
    logic [5:0]  eth_rx_addr;
    logic [7:0]  eth_rx_wdata;
    logic        eth_rx_we;
    logic        eth_rx_ready;
    logic        eth_rx_read;
    logic [2:0]  fsm_state;

    logic [13:0] exp_q[$];
    logic [13:0] mon_exp;
    int          n_checks = 0;
    int          n_fail   = 0;

    packet_rx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data         (data),
        .ctl          (ctl),
        .mac_addr     (mac_addr),
        .eth_rx_addr  (eth_rx_addr),
        .eth_rx_wdata (eth_rx_wdata),
        .eth_rx_we    (eth_rx_we),
        .eth_rx_ready (eth_rx_ready),
        .eth_rx_read  (eth_rx_read),
        .fsm_state    (fsm_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every RAM write must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && eth_rx_we) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%0d data=%02h, required no write",
                         eth_rx_addr, eth_rx_wdata);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({eth_rx_addr, eth_rx_wdata} !== mon_exp) begin
                    n_fail++;
                    $display("FAIL ram_write: got addr=%0d data=%02h, required addr=%0d data=%02h",
                             eth_rx_addr, eth_rx_wdata, mon_exp[13:8], mon_exp[7:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic send_byte(input logic [1:0] c, input logic [7:0] d);
        @(negedge clk);
        ctl  = c;
        data = d;
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) send_byte(2'b00, 8'h00);
    endtask

    task automatic pulse_read();
        @(negedge clk);
        eth_rx_read = 1'b1;
        @(negedge clk);
        eth_rx_read = 1'b0;
    endtask

    // One frame: bad_mac selects a corrupted dest byte (-1 none), bad_src
    // corrupts header byte 6, npay payload bytes, err_at injects ctl=01 at
    // that payload index (-1 none), expect_wr pushes the expected writes.
    task automatic send_frame(input int bad_mac, input bit bad_src, input int npay,
                              input int err_at, input bit expect_wr);
        logic [7:0] b;
        for (int i = 0; i < 4; i++) send_byte(2'b11, 8'h55);
        send_byte(2'b11, 8'hD5);
        for (int i = 0; i < 6; i++) begin
            b = MAC[47 - 8*i -: 8];
            if (i == bad_mac) b = 8'h33;
            send_byte(2'b11, b);
        end
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom_range(0, 255));
            if (i == 0 && bad_src) b = 8'h33;
            send_byte(2'b11, b);
        end
        for (int k = 0; k < npay; k++) begin
            if (k == err_at) begin
                send_byte(2'b01, 8'h00);
                break;
            end
            b = 8'(k * 5);
            if (expect_wr) exp_q.push_back({6'(k), b});
            send_byte(2'b11, b);
        end
        if (npay == 64 && err_at < 0) begin
            for (int i = 0; i < 36; i++) send_byte(2'b11, 8'($urandom_range(0, 255)));
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        ctl         = 2'b00;
        data        = 8'h00;
        eth_rx_read = 1'b0;
        mac_addr    = MAC;
        repeat (3) @(negedge clk);
        check("reset_we",    32'(eth_rx_we),    32'h0);
        check("reset_addr",  32'(eth_rx_addr),  32'h0);
        check("reset_wdata", 32'(eth_rx_wdata), 32'h0);
        check("reset_ready", 32'(eth_rx_ready), 32'h0);
        check("reset_state", 32'(fsm_state),    32'h0);
        rst_n = 1'b1;
        send_idle(2);

        // Accepted frame; ready only after ctl drops.
        send_frame(-1, 1'b0, 64, -1, 1'b1);
        check("ready_before_end", 32'(eth_rx_ready), 32'h0);
        send_idle(4);
        check("ready_after_frame", 32'(eth_rx_ready), 32'h1);
        check("all_writes_seen_1", 32'(exp_q.size()), 32'h0);

        // Frame while buffer owned by CPU: dropped, no writes.
        send_frame(-1, 1'b0, 64, -1, 1'b0);
        send_idle(4);
        check("ready_held", 32'(eth_rx_ready), 32'h1);

        // Release and accept an identical frame.
        pulse_read();
        send_idle(2);
        check("ready_released", 32'(eth_rx_ready), 32'h0);
        send_frame(-1, 1'b0, 64, -1, 1'b1);
        send_idle(4);
        check("ready_second_frame", 32'(eth_rx_ready), 32'h1);
        check("all_writes_seen_2", 32'(exp_q.size()), 32'h0);
        pulse_read();
        send_idle(2);
        check("ready_released_2", 32'(eth_rx_ready), 32'h0);

        // Each dest MAC byte corrupted in turn.
        for (int i = 0; i < 6; i++) begin
            send_frame(i, 1'b0, 64, -1, 1'b0);
            send_idle(4);
            check($sformatf("mac_bad_%0d_ready", i), 32'(eth_rx_ready), 32'h0);
        end

        // Source MAC is not inspected.
        send_frame(-1, 1'b1, 64, -1, 1'b1);
        send_idle(4);
        check("src_bad_ready", 32'(eth_rx_ready), 32'h1);
        check("all_writes_seen_3", 32'(exp_q.size()), 32'h0);
        pulse_read();
        send_idle(2);

        // Runt frame: 40 bytes written, no ready.
        send_frame(-1, 1'b0, 40, -1, 1'b1);
        send_idle(4);
        check("runt_ready", 32'(eth_rx_ready), 32'h0);
        check("all_writes_seen_4", 32'(exp_q.size()), 32'h0);

        // Receive error mid-payload.
        send_frame(-1, 1'b0, 64, 20, 1'b1);
        for (int i = 0; i < 60; i++) send_byte(2'b11, 8'hAA);
        send_idle(4);
        check("err_ready", 32'(eth_rx_ready), 32'h0);
        check("all_writes_seen_5", 32'(exp_q.size()), 32'h0);

        // Reset in the middle of CAPTURE.
        send_frame(-1, 1'b0, 10, -1, 1'b1);
        send_byte(2'b11, 8'd50);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_we",    32'(eth_rx_we),    32'h0);
        check("midrst_addr",  32'(eth_rx_addr),  32'h0);
        check("midrst_wdata", 32'(eth_rx_wdata), 32'h0);
        check("midrst_state", 32'(fsm_state),    32'h0);
        check("midrst_writes_seen", 32'(exp_q.size()), 32'h0);
        ctl  = 2'b00;
        data = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_idle(2);
        send_frame(-1, 1'b0, 64, -1, 1'b1);
        send_idle(4);
        check("post_reset_ready", 32'(eth_rx_ready), 32'h1);
        check("all_writes_seen_6", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
